// File: rtl/uart_pkg.sv
// Shared encodings and elaboration-time helpers for the UART transmitter.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Phase-accumulator increment: (BAUD_RATE << ACC_WIDTH) / CLK_FREQ, truncated.
    function automatic logic [63:0] calc_inc(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned acc_width);
        return (64'(baud_rate) << acc_width) / 64'(clk_freq);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and fall-through read data.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle's write/pop; simultaneous write and pop cancel.
    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers, count and registered flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array; contents need no reset since the flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter toward the FTDI bridge with a write FIFO and configurable frame format.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          FTDI_DTR,
    output logic                          FTDI_RX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          baud_tick
);

    localparam int unsigned     BCW     = $clog2(DATA_BITS);
    localparam logic [ACC_WIDTH-1:0] INC = ACC_WIDTH'(calc_inc(CLK_FREQ, BAUD_RATE, ACC_WIDTH));
    localparam bit              HAS_PAR = (PARITY != PAR_NONE);
    localparam bit              ODD_PAR = (PARITY == PAR_ODD);

    state_t                 state;
    state_t                 state_nxt;
    logic [DATA_BITS-1:0]   sh;
    logic [DATA_BITS-1:0]   sh_nxt;
    logic [BCW-1:0]         bit_cnt;
    logic [BCW-1:0]         bit_cnt_nxt;
    logic                   stop_cnt;
    logic                   stop_cnt_nxt;
    logic                   par_bit;
    logic                   par_nxt;
    logic                   rx_nxt;
    logic                   pop;
    logic                   can_pop;
    logic [ACC_WIDTH:0]     acc;
    logic [DATA_BITS-1:0]   fifo_rd;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign wr_ready  = ~fifo_full;
    assign baud_tick = acc[ACC_WIDTH];
    assign can_pop   = ~fifo_empty & FTDI_DTR;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_valid & wr_ready),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Frame sequencing; a pop loads the shift register and latches the parity bit.
    always_comb begin
        state_nxt    = state;
        sh_nxt       = sh;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        par_nxt      = par_bit;
        pop          = 1'b0;
        rx_nxt       = 1'b1;

        case (state)
            ST_IDLE: begin
                if (can_pop) begin
                    pop       = 1'b1;
                    sh_nxt    = fifo_rd;
                    par_nxt   = (^fifo_rd) ^ ODD_PAR;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    sh_nxt = sh >> 1;
                    if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = HAS_PAR ? ST_PAR : ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (baud_tick) begin
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        if (can_pop) begin
                            pop       = 1'b1;
                            sh_nxt    = fifo_rd;
                            par_nxt   = (^fifo_rd) ^ ODD_PAR;
                            state_nxt = ST_START;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Line level follows the state being entered so it lines up with that state.
        case (state_nxt)
            ST_START: rx_nxt = 1'b0;
            ST_DATA:  rx_nxt = sh_nxt[0];
            ST_PAR:   rx_nxt = par_nxt;
            default:  rx_nxt = 1'b1;
        endcase
    end

    // State, datapath and registered outputs; the accumulator runs only while a frame is active.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sh       <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            FTDI_RX  <= 1'b1;
            busy     <= 1'b0;
            acc      <= '0;
        end else begin
            state    <= state_nxt;
            sh       <= sh_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            par_bit  <= par_nxt;
            FTDI_RX  <= rx_nxt;
            busy     <= (state_nxt != ST_IDLE);
            if (state_nxt != ST_IDLE) begin
                acc <= {1'b0, acc[ACC_WIDTH-1:0]} + {1'b0, INC};
            end else begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats, scoreboard of expected serial frames.
module tb_uart_tx_fifo;

    localparam int unsigned BIT_CYC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] wv, wrr, dtr, rx, busy, tick;
    logic [8:0] wd [4];
    logic [2:0] fc0;
    logic [4:0] fc1;
    logic [3:0] fc2, fc3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int st0[$];
    logic [15:0] q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD_RATE(1), .ACC_WIDTH(8), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .wr_data(wd[0][7:0]), .wr_valid(wv[0]), .wr_ready(wrr[0]),
        .FTDI_DTR(dtr[0]), .FTDI_RX(rx[0]), .busy(busy[0]), .fifo_count(fc0), .baud_tick(tick[0]));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD_RATE(1), .ACC_WIDTH(8), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .reset(reset), .wr_data(wd[1][7:0]), .wr_valid(wv[1]), .wr_ready(wrr[1]),
        .FTDI_DTR(dtr[1]), .FTDI_RX(rx[1]), .busy(busy[1]), .fifo_count(fc1), .baud_tick(tick[1]));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD_RATE(1), .ACC_WIDTH(8), .DATA_BITS(7),
                   .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u2 (
        .clk(clk), .reset(reset), .wr_data(wd[2][6:0]), .wr_valid(wv[2]), .wr_ready(wrr[2]),
        .FTDI_DTR(dtr[2]), .FTDI_RX(rx[2]), .busy(busy[2]), .fifo_count(fc2), .baud_tick(tick[2]));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD_RATE(1), .ACC_WIDTH(8), .DATA_BITS(7),
                   .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8)) u3 (
        .clk(clk), .reset(reset), .wr_data(wd[3][6:0]), .wr_valid(wv[3]), .wr_ready(wrr[3]),
        .FTDI_DTR(dtr[3]), .FTDI_RX(rx[3]), .busy(busy[3]), .fifo_count(fc3), .baud_tick(tick[3]));

    // Frame format of each instance.
    function automatic int dbits(input int i);
        return (i >= 2) ? 7 : 8;
    endfunction
    function automatic int pmode(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int sbits(input int i);
        return (i >= 2) ? 2 : 1;
    endfunction
    function automatic int flen(input int i);
        return 1 + dbits(i) + ((pmode(i) != 0) ? 1 : 0) + sbits(i);
    endfunction

    // Reference frame: line levels in transmission order, bit 0 first.
    function automatic logic [15:0] frame(input int i, input logic [8:0] d);
        logic [15:0] f;
        int ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < dbits(i); k++) begin
            f[1 + k] = d[k];
            ones += int'(d[k]);
        end
        if (pmode(i) == 2) f[1 + dbits(i)] = ((ones % 2) == 1);
        if (pmode(i) == 1) f[1 + dbits(i)] = ((ones % 2) == 0);
        return f;
    endfunction

    function automatic void qpush(input int i, input logic [15:0] f);
        case (i)
            0:       q0.push_back(f);
            1:       q1.push_back(f);
            2:       q2.push_back(f);
            default: q3.push_back(f);
        endcase
    endfunction
    function automatic logic [15:0] qpop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            2:       return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction
    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic void check(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Offer one word (caller sits at a negedge); returns at the negedge after acceptance.
    task automatic wr(input int i, input logic [8:0] d, input int budget);
        bit ok;
        ok    = 1'b0;
        wd[i] = d;
        wv[i] = 1'b1;
        for (int k = 0; k < budget && !ok; k++) begin
            if (wrr[i]) begin
                @(posedge clk);
                qpush(i, frame(i, d));
                ok = 1'b1;
                #1 wv[i] = 1'b0;
            end
            @(negedge clk);
        end
        wv[i] = 1'b0;
        check(ok, $sformatf("u%0d write 0x%0h accepted", i, d), int'(ok), 1);
    endtask

    // Wait until everything queued for instance i has been sent.
    task automatic wait_idle(input int i, input int budget);
        int k;
        k = 0;
        while ((qsize(i) != 0 || busy[i]) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(k < budget, $sformatf("u%0d drain within %0d cycles", i, budget), k, budget);
    endtask

    // Monitor: each falling line is a frame start; every bit must hold its level for BIT_CYC cycles.
    task automatic mon(input int i);
        logic [15:0] f;
        int good;
        bit abort;
        forever begin
            @(negedge clk);
            if (reset && !rx[i]) begin
                if (qsize(i) == 0) begin
                    check(1'b0, $sformatf("u%0d unexpected frame at cycle %0d", i, cyc), 1, 0);
                    for (int k = 0; k < 400 && !rx[i]; k++) @(negedge clk);
                end else begin
                    f     = qpop(i);
                    abort = 1'b0;
                    if (i == 0) st0.push_back(cyc);
                    for (int b = 0; b < flen(i) && !abort; b++) begin
                        good = 0;
                        for (int c = 0; c < BIT_CYC; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (!reset) begin
                                abort = 1'b1;
                                break;
                            end
                            if (rx[i] == f[b]) good++;
                        end
                        if (!abort)
                            check(good == BIT_CYC,
                                  $sformatf("u%0d frame bit %0d (level %0d) cycles held", i, b, f[b]),
                                  good, BIT_CYC);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nt, nl;
        logic [8:0] d;

        reset = 1'b0;
        wv    = '0;
        dtr   = '1;
        for (int i = 0; i < 4; i++) wd[i] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check(rx == 4'hF,   "reset line high", int'(rx), 15);
        check(busy == 4'h0, "reset busy", int'(busy), 0);
        check(wrr == 4'hF,  "reset wr_ready", int'(wrr), 15);
        check(fc0 == 3'd0,  "reset fifo_count", int'(fc0), 0);
        check(tick == 4'h0, "reset baud_tick", int'(tick), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single 8N1 frame: latency, busy length and tick count
        wr(0, 9'h055, 4);
        check(rx[0] == 1'b1, "u0 line still high write+1", int'(rx[0]), 1);
        @(negedge clk);
        check(rx[0] == 1'b0, "u0 start bit at write+2", int'(rx[0]), 0);
        nb = 0;
        nt = 0;
        for (int k = 0; k < 400 && busy[0]; k++) begin
            nb++;
            nt += int'(tick[0]);
            @(negedge clk);
        end
        check(nb == 160, "u0 busy cycles for one frame", nb, 160);
        check(nt == 10,  "u0 baud ticks in one frame", nt, 10);
        check(rx[0] == 1'b1, "u0 idle after frame", int'(rx[0]), 1);

        // Depth-4 FIFO with DTR low, then back-to-back drain
        dtr[0] = 1'b0;
        for (int k = 1; k <= 4; k++) wr(0, 9'(k), 4);
        check(wrr[0] == 1'b0, "u0 wr_ready when full", int'(wrr[0]), 0);
        check(fc0 == 3'd4,    "u0 fifo_count when full", int'(fc0), 4);
        wd[0] = 9'h005;
        wv[0] = 1'b1;
        repeat (3) @(negedge clk);
        check(fc0 == 3'd4,     "u0 write while full ignored", int'(fc0), 4);
        check(busy[0] == 1'b0, "u0 no frame while DTR low", int'(busy[0]), 0);
        st0.delete();
        dtr[0] = 1'b1;
        wr(0, 9'h005, 10);
        wait_idle(0, 1200);
        check(st0.size() == 5, "u0 frames after DTR raise", st0.size(), 5);
        for (int k = 1; k < st0.size(); k++)
            check(st0[k] - st0[k-1] == 160, $sformatf("u0 start spacing frame %0d", k),
                  st0[k] - st0[k-1], 160);

        // Reset mid-frame with two entries queued
        wr(0, 9'h0A5, 4);
        wr(0, 9'h03C, 4);
        wr(0, 9'h00F, 4);
        repeat (40) @(negedge clk);
        check(fc0 == 3'd2,     "u0 queued before reset", int'(fc0), 2);
        check(busy[0] == 1'b1, "u0 busy before reset", int'(busy[0]), 1);
        #2 reset = 1'b0;
        #1;
        check(rx[0] == 1'b1,   "u0 line high at async reset", int'(rx[0]), 1);
        check(busy[0] == 1'b0, "u0 busy cleared at async reset", int'(busy[0]), 0);
        check(fc0 == 3'd0,     "u0 fifo_count cleared at async reset", int'(fc0), 0);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        nb = 0;
        nl = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            nb += int'(busy[0]);
            nl += int'(!rx[0]);
        end
        check(nb == 0, "u0 busy cycles after reset without write", nb, 0);
        check(nl == 0, "u0 low line cycles after reset without write", nl, 0);
        wr(0, 9'h099, 4);
        wait_idle(0, 400);

        // DTR dropped during the start bit of the first of two frames
        dtr[0] = 1'b0;
        wr(0, 9'h011, 4);
        wr(0, 9'h022, 4);
        dtr[0] = 1'b1;
        for (int k = 0; k < 10 && rx[0]; k++) @(negedge clk);
        check(rx[0] == 1'b0, "u0 first frame started", int'(rx[0]), 0);
        repeat (3) @(negedge clk);
        dtr[0] = 1'b0;
        for (int k = 0; k < 300 && busy[0]; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        check(busy[0] == 1'b0, "u0 idle while DTR low", int'(busy[0]), 0);
        check(rx[0] == 1'b1,   "u0 line high while DTR low", int'(rx[0]), 1);
        check(fc0 == 3'd1,     "u0 second frame held", int'(fc0), 1);
        dtr[0] = 1'b1;
        @(negedge clk);
        check(rx[0] == 1'b0, "u0 second frame starts 1 cycle after DTR", int'(rx[0]), 0);
        wait_idle(0, 400);

        // Parity / 7-bit / 2-stop formats: directed word then random traffic with random DTR
        for (int i = 1; i < 4; i++) begin
            wr(i, (i == 3) ? 9'h041 : 9'h007, 4);
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                dtr[i] = (qsize(i) >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
                d = 9'($urandom_range(0, (1 << dbits(i)) - 1));
                wr(i, d, 2000);
            end
            dtr[i] = 1'b1;
            wait_idle(i, 4000);
            check(rx[i] == 1'b1, $sformatf("u%0d idle line after traffic", i), int'(rx[i]), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte FTDI serial transmitter: the UART TX path toward the FTDI bridge, now with configurable frame format and an internal write FIFO.
- Frame format: data width, parity and stop-bit count are configurable.
- FIFO: producers queue bytes with a valid/ready handshake and do not wait for each frame to finish.
- Back-to-back transmission: queued frames go out with no idle gap.
- Gating: the FTDI_DTR input gates the start of each new frame.
- Placement: sits between on-chip producers and the FTDI_RX pin.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate in bit/s
ACC_WIDTH, 32, phase-accumulator width; INC = (BAUD_RATE << ACC_WIDTH) / CLK_FREQ, truncated, computed at elaboration
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, entries, power of two, minimum 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
wr_data  in  DATA_BITS  payload to queue
wr_valid  in  1  producer offers wr_data
wr_ready  out  1  FIFO not full; a write is accepted on a cycle with wr_valid & wr_ready
FTDI_DTR  in  1  host ready; 1 permits starting a new frame
FTDI_RX  out  1  serial line toward the FTDI chip, idle high
busy  out  1  1 whenever state is not IDLE
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued
baud_tick  out  1  one-cycle pulse, carry out of the phase accumulator

Behaviour:
- Reset (reset=0, asynchronous):
  - FTDI_RX=1, busy=0, wr_ready=1, fifo_count=0, baud_tick=0.
  - State=IDLE; FIFO pointers and accumulator cleared.
  - Applies mid-frame too: the line returns high at once and the partial frame is dropped.
- FIFO:
  - Synchronous, registered full and empty flags.
  - Write and pop in the same cycle are both honoured; count is unchanged.
  - A write while full is impossible (wr_ready=0) and is ignored.
- Baud generator:
  - acc[ACC_WIDTH:0] <= acc[ACC_WIDTH-1:0] + INC while busy; acc is held at 0 in IDLE.
  - baud_tick = acc[ACC_WIDTH].
  - The first bit of a frame is therefore a full period; there is no fractional leftover from the previous frame.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if FIFO non-empty and FTDI_DTR=1, pop the head into shift register sh and go to START.
  - START: FTDI_RX=0; on baud_tick go to DATA with bit_cnt=0.
  - DATA: FTDI_RX=sh[0], LSB first. On baud_tick, shift right and increment bit_cnt. After bit DATA_BITS-1, go to PAR if PARITY!=0, else STOP.
  - PAR: FTDI_RX = parity over the popped word. Even: XOR of the data bits (total ones even). Odd: inverse of that. The value is registered at pop time. On baud_tick go to STOP with stop_cnt=0.
  - STOP: FTDI_RX=1. On baud_tick with stop_cnt=STOP_BITS-1:
    - if FIFO non-empty and FTDI_DTR=1, pop and go directly to START (back-to-back, zero gap);
    - else go to IDLE.
    - Otherwise (more stop bits remain) increment stop_cnt.
- FTDI_RX is registered, driven from the current state and shift register.
- Latency: a write accepted in cycle N with FIFO empty, IDLE and DTR=1 gives FIFO non-empty in N+1, pop at the end of N+1, and FTDI_RX=0 from N+2.
- FTDI_DTR dropping mid-frame: the current frame completes; no new frame starts until DTR=1 again.
- Frame length: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS baud periods.

Decomposition:
- Package uart_pkg holds:
  - the parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - the FSM state localparams, 3-bit;
  - the INC computation function.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; ports clk, reset, wr_en, wr_data, rd_en, rd_data, full, empty, count), instantiated once.

Test Plan:
- Defaults except CLK_FREQ=16, BAUD_RATE=1, ACC_WIDTH=8 (INC=16, tick every 16 cycles): write 0x55 -> FTDI_RX=0 from write+2, then 1,0,1,0,1,0,1,0, then stop 1, each exactly 16 cycles; busy high for 160 cycles; then IDLE.
- PARITY=2, write 0x07 -> parity bit 1. PARITY=1, write 0x07 -> parity bit 0. Both with 11-bit frames.
- DATA_BITS=7, STOP_BITS=2, write 0x41 -> 0,1,0,0,0,0,0,1,1,1; total 10 periods.
- FIFO_DEPTH=4, FTDI_DTR=0, offer 5 writes (0x01..0x05) -> 4 accepted, wr_ready=0, fifo_count=4. Raise DTR -> frames 0x01..0x04 back-to-back with no idle cycle between stop and next start. The fifth write is accepted once the first pop frees a slot.
- Assert reset=0 mid-data-bit of a frame with 2 entries queued -> FTDI_RX=1 in the same cycle, fifo_count=0, busy=0. After release no frame is sent until a new write.
- FTDI_DTR dropped during the START bit of frame 1 of 2 queued -> frame 1 completes and the line stays high with fifo_count=1. DTR restored -> frame 2 starts 1 cycle later.
